// File: rtl/mmio_pkg.sv
// Shared constants and types for the MMIO countdown bus initiator.
package mmio_pkg;

  localparam int unsigned DefAddrW = 30;
  localparam int unsigned DefDataW = 32;
  localparam int unsigned CountW   = 16;

  localparam logic [DefAddrW-1:0] DefSwAddr  = 30'h0000_0040;
  localparam logic [DefAddrW-1:0] DefLedAddr = 30'h0000_0080;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR,
    WAIT
  } state_t;

endpackage

// File: rtl/mmio_countdown_master_if.sv
// Memory-mapped peripheral bus: word address, write/read strobes and data.
interface mmio_countdown_master_if #(
  parameter int unsigned ADDR_W = mmio_pkg::DefAddrW,
  parameter int unsigned DATA_W = mmio_pkg::DefDataW
);

  logic [ADDR_W-1:0] memAddress;
  logic [DATA_W-1:0] writeData;
  logic              writeEnable;
  logic              readEnable;
  logic [DATA_W-1:0] readData;

  modport master (
    output memAddress,
    output writeData,
    output writeEnable,
    output readEnable,
    input  readData
  );

  modport slave (
    input  memAddress,
    input  writeData,
    input  writeEnable,
    input  readEnable,
    output readData
  );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running divider for the countdown: counts while enabled and pulses expire on the
// last cycle of each TICK_DIV-cycle period. Held at zero while clear is high.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expire
);

  localparam int unsigned TickW = $clog2(TICK_DIV);
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);

  logic [TickW-1:0] tick_q, tick_d;

  assign expire = ~clear & (tick_q == TickMax);

  always_comb begin
    tick_d = tick_q + TickW'(1);
    if (clear || expire) begin
      tick_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/mmio_countdown_master.sv
// Bus initiator: polls the switch register, then writes a countdown N..0 to the LED
// register, one write per prescaler period.
module mmio_countdown_master
  import mmio_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DefAddrW,
  parameter int unsigned       DATA_W   = DefDataW,
  parameter logic [ADDR_W-1:0] SW_ADDR  = DefSwAddr,
  parameter logic [ADDR_W-1:0] LED_ADDR = DefLedAddr,
  parameter int unsigned       TICK_DIV = 100_000_000
) (
  input  logic                clk,
  input  logic                rst,
  mmio_countdown_master_if.master bus,
  output logic                busy,
  output logic [CountW-1:0]   count_out
);

  state_t            state_q, state_d;
  logic [CountW-1:0] count_q, count_d;
  logic              tick_clear;
  logic              expire;
  logic              unused_rd_hi;

  // Only the low half of the switch register carries the count.
  assign unused_rd_hi = ^bus.readData[DATA_W-1:CountW];

  assign tick_clear = (state_q != WAIT);
  assign count_out  = count_q;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (tick_clear),
    .expire(expire)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        count_d = bus.readData[CountW-1:0];
        state_d = (bus.readData[CountW-1:0] == '0) ? IDLE : WR;
      end
      WR: begin
        state_d = (count_q == '0) ? IDLE : WAIT;
      end
      WAIT: begin
        if (expire) begin
          count_d = count_q - CountW'(1);
          state_d = WR;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Moore outputs, qualified by rst so the bus stays idle while reset is held.
  always_comb begin
    bus.readEnable  = 1'b0;
    bus.writeEnable = 1'b0;
    bus.memAddress  = '0;
    bus.writeData   = '0;
    busy            = 1'b0;
    if (rst) begin
      unique case (state_q)
        IDLE: begin
          bus.readEnable = 1'b1;
          bus.memAddress = SW_ADDR;
        end
        WR: begin
          bus.writeEnable              = 1'b1;
          bus.memAddress               = LED_ADDR;
          bus.writeData[CountW-1:0]    = count_q;
          busy                         = 1'b1;
        end
        WAIT: begin
          busy = 1'b1;
        end
        default: begin
          busy = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_countdown_master.sv
// Scoreboard bench: stimulus queues expected bus strobes, a negedge monitor checks them.
module tb_mmio_countdown_master;

  localparam int unsigned TickDiv = 4;
  localparam logic [29:0] SwAddr  = 30'h0000_0040;
  localparam logic [29:0] LedAddr = 30'h0000_0080;

  typedef struct {
    bit          is_wr;
    logic [29:0] addr;
    logic [31:0] data;
    int          gap;   // cycles since previous strobe; 0 = don't check
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        busy;
  logic [15:0] count_out;

  mmio_countdown_master_if bus ();

  mmio_countdown_master #(
    .SW_ADDR (SwAddr),
    .LED_ADDR(LedAddr),
    .TICK_DIV(TickDiv)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .count_out(count_out)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   last_cyc = 0;
  int   pending  = 0;
  bit   mon_en   = 1'b0;
  txn_t exp_q[$];
  txn_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic push(input bit is_wr, input logic [29:0] addr, input logic [31:0] data,
                      input int gap);
    txn_t t;
    t.is_wr = is_wr;
    t.addr  = addr;
    t.data  = data;
    t.gap   = gap;
    exp_q.push_back(t);
    pending++;
  endtask

  task automatic push_rd(input int gap);
    push(1'b0, SwAddr, 32'h0, gap);
  endtask

  // First write follows the capturing read by 2 cycles, later ones by TICK_DIV+1.
  task automatic push_countdown(input int n);
    push(1'b1, LedAddr, 32'(n), 2);
    for (int v = n - 1; v >= 0; v--) push(1'b1, LedAddr, 32'(v), 5);
  endtask

  task automatic wait_pending(input int target, input string what);
    int deadline;
    deadline = cyc + 400;
    wait (pending == target || cyc >= deadline);
    if (pending != target) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: pending=%0d, expected %0d", what, pending, target);
      finish_sim();
    end
  endtask

  task automatic check_idle(input string what);
    check({what, "_re"},    32'(bus.readEnable), 32'h0);
    check({what, "_we"},    32'(bus.writeEnable), 32'h0);
    check({what, "_addr"},  32'(bus.memAddress), 32'h0);
    check({what, "_wdata"}, bus.writeData, 32'h0);
    check({what, "_busy"},  32'(busy), 32'h0);
    check({what, "_count"}, 32'(count_out), 32'h0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("strobe_exclusive", 32'(bus.readEnable & bus.writeEnable), 32'h0);
      if (bus.readEnable || bus.writeEnable) begin
        if (pending == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: we=%0b re=%0b addr=0x%0h data=0x%0h, expected none",
                   bus.writeEnable, bus.readEnable, bus.memAddress, bus.writeData);
        end else begin
          mon_e = exp_q.pop_front();
          pending--;
          check("strobe_kind", 32'({bus.writeEnable, bus.readEnable}),
                mon_e.is_wr ? 32'h2 : 32'h1);
          check("strobe_addr", 32'(bus.memAddress), 32'(mon_e.addr));
          check("strobe_wdata", bus.writeData, mon_e.data);
          check("strobe_busy", 32'(busy), mon_e.is_wr ? 32'h1 : 32'h0);
          check("strobe_count", 32'(count_out), mon_e.is_wr ? mon_e.data : 32'h0);
          if (mon_e.gap != 0) check("strobe_gap", 32'(cyc - last_cyc), 32'(mon_e.gap));
        end
        last_cyc = cyc;
      end else begin
        check("idle_addr", 32'(bus.memAddress), 32'h0);
        check("idle_wdata", bus.writeData, 32'h0);
      end
    end
  end

  initial begin
    #20000;
    checks++;
    errors++;
    $display("FAIL global_timeout: simulation did not complete, pending=%0d", pending);
    finish_sim();
  end

  initial begin
    // Reset held with all switch bits set: bus must stay quiet.
    bus.readData = 32'hFFFF_FFFF;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      check_idle("reset");
    end

    // Zero switches: reads every 2 cycles, no writes. The 4th read returns 3.
    bus.readData = 32'h0;
    push_rd(0);
    for (int i = 0; i < 3; i++) push_rd(2);
    rst = 1'b1;
    @(negedge clk);
    check("first_read_re", 32'(bus.readEnable), 32'h1);
    check("first_read_addr", 32'(bus.memAddress), 32'(SwAddr));
    wait_pending(0, "poll_zero");

    bus.readData = 32'h0000_0003;
    push_countdown(3);
    wait_pending(0, "count3");

    // Upper half of the switch register is ignored.
    bus.readData = 32'hABCD_0002;
    push_rd(1);
    push_countdown(2);
    wait_pending(0, "upper_bits");

    // Switch change during a countdown has no effect.
    bus.readData = 32'h0000_0005;
    push_rd(1);
    push_countdown(5);
    wait_pending(5, "count5_first");
    bus.readData = 32'h0000_0009;
    wait_pending(0, "count5");

    bus.readData = 32'h0;
    push_rd(1);
    push_rd(2);
    wait_pending(0, "poll_after_change");

    // Reset in the WAIT following the write of 4.
    bus.readData = 32'h0000_0006;
    push(1'b1, LedAddr, 32'h6, 2);
    push(1'b1, LedAddr, 32'h5, 5);
    push(1'b1, LedAddr, 32'h4, 5);
    wait_pending(0, "count6");
    @(posedge clk);
    #1;
    check("wait_busy", 32'(busy), 32'h1);
    check("wait_count", 32'(count_out), 32'h4);
    check("wait_we", 32'(bus.writeEnable), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_idle("reset_mid");
    @(posedge clk);
    #1;
    check_idle("reset_mid_hold");

    bus.readData = 32'h0000_0002;
    push_rd(0);
    push_countdown(2);
    rst = 1'b1;
    wait_pending(0, "restart");

    bus.readData = 32'h0;
    push_rd(1);
    push_rd(2);
    wait_pending(0, "final_poll");

    finish_sim();
  end

endmodule
